// File: rtl/axis_bram_adapter_v1_0_sched_pkg.sv
// Shared types and constants for the AXIS/BRAM adapter job scheduler.
package axis_bram_adapter_v1_0_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADP_RST = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WR_RUN  = 3'd3,
        ST_RD_RUN  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Number of cycles the adapter is held in reset before each job.
    localparam int ADP_RST_CYCLES = 2;

    // Grant / job-type encoding, shared with adp_rw and done_rw.
    localparam logic GNT_WR = 1'b1;
    localparam logic GNT_RD = 1'b0;

endpackage

// File: rtl/axis_bram_adapter_v1_0_sched_if.sv
// Job request, stream gating and adapter control bundle of the scheduler.
interface axis_bram_adapter_v1_0_sched_if #(
    parameter int BRAM_DEPTH = 12
);
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [BRAM_DEPTH-1:0] wr_req_start;
    logic [BRAM_DEPTH-1:0] wr_req_bound;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [BRAM_DEPTH-1:0] rd_req_start;
    logic [BRAM_DEPTH-1:0] rd_req_bound;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  m_axis_tready;
    logic                  m_axis_tvalid;
    logic                  adp_rstn;
    logic                  adp_rw;
    logic                  adp_addr_reload;
    logic [BRAM_DEPTH-1:0] adp_start_index;
    logic [BRAM_DEPTH-1:0] adp_bound_index;
    logic                  adp_stream_in_valid;
    logic                  adp_stream_in_accep;
    logic                  adp_stream_out_accep;
    logic                  adp_stream_out_valid;
    logic                  adp_stream_out_tlast;
    logic                  busy;
    logic                  done;
    logic                  done_rw;
    logic                  err;

    // Scheduler side.
    modport master (
        input  wr_req_valid, wr_req_start, wr_req_bound,
        input  rd_req_valid, rd_req_start, rd_req_bound,
        input  s_axis_tvalid, m_axis_tready,
        input  adp_stream_in_accep, adp_stream_out_valid, adp_stream_out_tlast,
        output wr_req_ready, rd_req_ready, s_axis_tready, m_axis_tvalid,
        output adp_rstn, adp_rw, adp_addr_reload, adp_start_index, adp_bound_index,
        output adp_stream_in_valid, adp_stream_out_accep,
        output busy, done, done_rw, err
    );

    // Requester / stream / adapter side.
    modport slave (
        output wr_req_valid, wr_req_start, wr_req_bound,
        output rd_req_valid, rd_req_start, rd_req_bound,
        output s_axis_tvalid, m_axis_tready,
        output adp_stream_in_accep, adp_stream_out_valid, adp_stream_out_tlast,
        input  wr_req_ready, rd_req_ready, s_axis_tready, m_axis_tvalid,
        input  adp_rstn, adp_rw, adp_addr_reload, adp_start_index, adp_bound_index,
        input  adp_stream_in_valid, adp_stream_out_accep,
        input  busy, done, done_rw, err
    );

endinterface

// File: rtl/axis_bram_adapter_v1_0_rr_arb.sv
// Two-requester round-robin arbiter; a tie goes to the channel not served last.
module axis_bram_adapter_v1_0_rr_arb
    import axis_bram_adapter_v1_0_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    input  logic upd,
    input  logic upd_gnt,
    output logic gnt_vld,
    output logic gnt
);
    logic last_grant;

    // Remember the type of the last completed job; reset favours write first.
    always_ff @(posedge clk) begin
        if (rst)      last_grant <= GNT_RD;
        else if (upd) last_grant <= upd_gnt;
    end

    assign gnt_vld = en & (req_wr | req_rd);
    assign gnt     = (req_wr & req_rd) ? ~last_grant : req_wr;

endmodule

// File: rtl/axis_bram_adapter_v1_0_sched.sv
// Job scheduler: arbitrates write/read jobs, sequences the adapter through
// reset/reload, gates the stream handshakes and reports completion.
module axis_bram_adapter_v1_0_sched
    import axis_bram_adapter_v1_0_sched_pkg::*;
#(
    parameter int BRAM_DEPTH         = 12,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int CNT_W              = 6
) (
    input  logic clk,
    input  logic rst,
    axis_bram_adapter_v1_0_sched_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BRAM_WIDTH_IN_WORD - 1);

    state_t                state;
    logic                  rst_cnt;
    logic [CNT_W-1:0]      word_cnt;
    logic [BRAM_DEPTH:0]   row_cnt;
    logic                  adp_rw_q, done_q, done_rw_q, err_q;
    logic [BRAM_DEPTH-1:0] start_q, bound_q, span;
    logic [BRAM_DEPTH-1:0] req_start, req_bound;
    logic                  arb_vld, arb_gnt;
    logic                  in_wr, in_rd, wr_beat, rd_last;

    axis_bram_adapter_v1_0_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (~rst & (state == ST_IDLE)),
        .req_wr  (bus.wr_req_valid),
        .req_rd  (bus.rd_req_valid),
        .upd     (state == ST_DONE),
        .upd_gnt (adp_rw_q),
        .gnt_vld (arb_vld),
        .gnt     (arb_gnt)
    );

    assign req_start = (arb_gnt == GNT_WR) ? bus.wr_req_start : bus.rd_req_start;
    assign req_bound = (arb_gnt == GNT_WR) ? bus.wr_req_bound : bus.rd_req_bound;
    assign span      = bound_q - start_q;

    assign in_wr   = (state == ST_WR_RUN);
    assign in_rd   = (state == ST_RD_RUN);
    assign wr_beat = in_wr & bus.s_axis_tvalid & bus.adp_stream_in_accep;
    assign rd_last = in_rd & bus.adp_stream_out_tlast & bus.adp_stream_out_valid
                     & bus.m_axis_tready;

    assign bus.wr_req_ready         = arb_vld & (arb_gnt == GNT_WR);
    assign bus.rd_req_ready         = arb_vld & (arb_gnt == GNT_RD);
    assign bus.s_axis_tready        = in_wr & bus.adp_stream_in_accep;
    assign bus.adp_stream_in_valid  = in_wr & bus.s_axis_tvalid;
    assign bus.m_axis_tvalid        = in_rd & bus.adp_stream_out_valid;
    assign bus.adp_stream_out_accep = in_rd & bus.m_axis_tready;
    // Adapter sits in reset with the scheduler and during the pre-job window.
    assign bus.adp_rstn             = ~rst & (state != ST_ADP_RST);
    assign bus.adp_addr_reload      = (state == ST_LOAD);
    assign bus.adp_rw               = adp_rw_q;
    assign bus.adp_start_index      = start_q;
    assign bus.adp_bound_index      = bound_q;
    assign bus.busy                 = (state != ST_IDLE);
    assign bus.done                 = done_q;
    assign bus.done_rw              = done_rw_q;
    assign bus.err                  = err_q;

    // Job sequencer with registered pulses and job descriptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rst_cnt   <= 1'b0;
            word_cnt  <= '0;
            row_cnt   <= '0;
            adp_rw_q  <= GNT_WR;
            start_q   <= '0;
            bound_q   <= '0;
            done_q    <= 1'b0;
            done_rw_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: if (arb_vld) begin
                    adp_rw_q <= arb_gnt;
                    start_q  <= req_start;
                    bound_q  <= req_bound;
                    if (req_bound < req_start) begin
                        err_q     <= 1'b1;
                        done_rw_q <= arb_gnt;
                    end else begin
                        rst_cnt <= 1'b0;
                        state   <= ST_ADP_RST;
                    end
                end
                ST_ADP_RST: begin
                    if (rst_cnt == 1'(ADP_RST_CYCLES - 1)) state <= ST_LOAD;
                    rst_cnt <= rst_cnt + 1'b1;
                end
                ST_LOAD: begin
                    word_cnt <= '0;
                    row_cnt  <= '0;
                    state    <= (adp_rw_q == GNT_WR) ? ST_WR_RUN : ST_RD_RUN;
                end
                ST_WR_RUN: if (wr_beat) begin
                    if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        if (row_cnt == {1'b0, span}) begin
                            done_q    <= 1'b1;
                            done_rw_q <= adp_rw_q;
                            state     <= ST_DONE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                ST_RD_RUN: if (rd_last) begin
                    done_q    <= 1'b1;
                    done_rw_q <= adp_rw_q;
                    state     <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// Directed bench for the job scheduler with a small adapter read model.
module tb_axis_bram_adapter_v1_0_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rd_word = 0;
    int   rd_last_idx = 35;

    axis_bram_adapter_v1_0_sched_if #(.BRAM_DEPTH(12)) bus ();

    axis_bram_adapter_v1_0_sched #(
        .BRAM_DEPTH(12), .BRAM_WIDTH_IN_WORD(36), .CNT_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Adapter read model: word counter cleared by adp_rstn, tlast on the last word.
    always @(posedge clk) begin
        if (!bus.adp_rstn) rd_word <= 0;
        else if (bus.adp_stream_out_valid && bus.adp_stream_out_accep) rd_word <= rd_word + 1;
    end
    assign bus.adp_stream_out_tlast = (rd_word == rd_last_idx);

    typedef struct {
        logic        rw;
        logic [11:0] s;
        logic [11:0] b;
        logic        err;
        int          beats;
    } job_t;

    job_t jobs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs a granted job from the first ADP_RST cycle until back in IDLE.
    task automatic serve(input logic rw, input int exp_beats, input string nm);
        int   beats = 0;
        int   cyc = 0;
        logic leak = 1'b0;
        chk({nm, "_rstn_a"}, bus.adp_rstn, 0);
        chk({nm, "_reload_a"}, bus.adp_addr_reload, 0);
        step;
        chk({nm, "_rstn_b"}, bus.adp_rstn, 0);
        step;
        bus.s_axis_tvalid = 1; bus.adp_stream_in_accep = 1;
        bus.adp_stream_out_valid = 1; bus.m_axis_tready = 1;
        #1;
        chk({nm, "_reload"}, bus.adp_addr_reload, 1);
        chk({nm, "_rstn_load"}, bus.adp_rstn, 1);
        chk({nm, "_gate_load"}, {bus.s_axis_tready, bus.adp_stream_in_valid,
                                 bus.m_axis_tvalid, bus.adp_stream_out_accep}, 0);
        step;
        while (!bus.done && cyc < 2000) begin
            if (rw) begin
                bus.s_axis_tvalid = (cyc % 3 != 2);
                bus.adp_stream_in_accep = (cyc % 5 != 4);
                #1;
                if (bus.s_axis_tready && bus.s_axis_tvalid) beats++;
                if (bus.adp_stream_in_valid !== bus.s_axis_tvalid) leak = 1;
            end else begin
                bus.m_axis_tready = (cyc % 4 != 3);
                bus.adp_stream_out_valid = (cyc % 3 != 1);
                #1;
                if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
                if (bus.adp_stream_out_accep !== bus.m_axis_tready) leak = 1;
            end
            if (bus.wr_req_ready || bus.rd_req_ready) leak = 1;
            step;
            cyc++;
        end
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_done_rw"}, bus.done_rw, rw);
        chk({nm, "_beats"}, beats, exp_beats);
        chk({nm, "_leak"}, leak, 0);
        bus.s_axis_tvalid = 1; bus.adp_stream_in_accep = 1;
        bus.adp_stream_out_valid = 1; bus.m_axis_tready = 1;
        #1;
        chk({nm, "_gate_done"}, {bus.s_axis_tready, bus.m_axis_tvalid}, 0);
        step;
        chk({nm, "_done_clr"}, bus.done, 0);
        chk({nm, "_idle"}, bus.busy, 0);
    endtask

    task automatic run_job(input job_t j, input string nm);
        if (j.rw) begin
            bus.wr_req_valid = 1; bus.wr_req_start = j.s; bus.wr_req_bound = j.b;
        end else begin
            bus.rd_req_valid = 1; bus.rd_req_start = j.s; bus.rd_req_bound = j.b;
        end
        rd_last_idx = j.beats - 1;
        #1;
        chk({nm, "_ready"}, {bus.wr_req_ready, bus.rd_req_ready}, j.rw ? 2'b10 : 2'b01);
        step;
        bus.wr_req_valid = 0; bus.rd_req_valid = 0;
        if (j.err) begin
            chk({nm, "_err"}, bus.err, 1);
            chk({nm, "_err_rw"}, bus.done_rw, j.rw);
            chk({nm, "_err_quiet"}, {bus.busy, bus.adp_rstn, bus.adp_addr_reload}, 3'b010);
            step;
            chk({nm, "_err_clr"}, {bus.err, bus.busy, bus.adp_rstn}, 3'b001);
        end else begin
            chk({nm, "_idx"}, {bus.adp_rw, bus.adp_start_index, bus.adp_bound_index},
                {j.rw, j.s, j.b});
            serve(j.rw, j.beats, nm);
        end
    endtask

    initial begin
        int beats;
        jobs[0] = '{1'b1, 12'd0,    12'd1,    1'b0, 72};
        jobs[1] = '{1'b0, 12'd0,    12'd0,    1'b0, 36};
        jobs[2] = '{1'b1, 12'd5,    12'd3,    1'b1, 0};
        jobs[3] = '{1'b0, 12'd10,   12'd2,    1'b1, 0};
        jobs[4] = '{1'b1, 12'd7,    12'd7,    1'b0, 36};
        jobs[5] = '{1'b0, 12'd3,    12'd5,    1'b0, 108};
        jobs[6] = '{1'b1, 12'd4095, 12'd4095, 1'b0, 36};

        bus.wr_req_valid = 1; bus.wr_req_start = 0; bus.wr_req_bound = 0;
        bus.rd_req_valid = 0; bus.rd_req_start = 0; bus.rd_req_bound = 0;
        bus.s_axis_tvalid = 1; bus.adp_stream_in_accep = 1;
        bus.m_axis_tready = 0; bus.adp_stream_out_valid = 0;

        // Reset state, requests held off while rst is high.
        step; step;
        chk("rst_ready", {bus.wr_req_ready, bus.rd_req_ready}, 0);
        chk("rst_flags", {bus.busy, bus.done, bus.err, bus.done_rw}, 0);
        chk("rst_adp", {bus.adp_rstn, bus.adp_rw, bus.adp_addr_reload}, 3'b010);
        chk("rst_idx", {bus.adp_start_index, bus.adp_bound_index}, 0);
        chk("rst_gate", {bus.s_axis_tready, bus.adp_stream_in_valid}, 0);
        bus.wr_req_valid = 0; rst = 0;
        #1;
        chk("rst_rstn_rel", bus.adp_rstn, 1);
        step;

        for (int i = 0; i < 7; i++) run_job(jobs[i], $sformatf("job%0d", i));

        // Read with downstream stall while tlast is presented.
        rd_last_idx = 35;
        bus.rd_req_valid = 1; bus.rd_req_start = 0; bus.rd_req_bound = 0;
        #1;
        chk("stall_ready", bus.rd_req_ready, 1);
        step;
        bus.rd_req_valid = 0;
        step; step; step;
        bus.adp_stream_out_valid = 1; bus.m_axis_tready = 1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.adp_stream_out_tlast) break;
            step;
        end
        chk("stall_tlast", bus.adp_stream_out_tlast, 1);
        bus.m_axis_tready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_hold", {bus.done, bus.busy, bus.m_axis_tvalid, bus.adp_stream_out_accep}, 4'b0110);
            step;
        end
        bus.m_axis_tready = 1;
        #1;
        step;
        chk("stall_done", {bus.done, bus.done_rw}, 2'b10);
        step;
        chk("stall_done_clr", bus.done, 0);

        // Reset in the middle of a write job.
        bus.wr_req_valid = 1; bus.wr_req_start = 2; bus.wr_req_bound = 2;
        bus.s_axis_tvalid = 1; bus.adp_stream_in_accep = 1;
        step;
        bus.wr_req_valid = 0;
        beats = 0;
        for (int c = 0; c < 100 && beats < 10; c++) begin
            #1;
            if (bus.s_axis_tready) beats++;
            step;
        end
        chk("mid_beats", beats, 10);
        rst = 1;
        #1;
        chk("mid_rstn", bus.adp_rstn, 0);
        step;
        chk("mid_state", {bus.busy, bus.done, bus.s_axis_tready, bus.adp_stream_in_valid}, 0);
        chk("mid_idx", {bus.adp_start_index, bus.adp_bound_index}, 0);
        rst = 0;
        step;

        // Both channels held high: W,R,W,R.
        rd_last_idx = 35;
        bus.wr_req_valid = 1; bus.wr_req_start = 0; bus.wr_req_bound = 0;
        bus.rd_req_valid = 1; bus.rd_req_start = 0; bus.rd_req_bound = 0;
        for (int k = 0; k < 4; k++) begin
            logic exp_w;
            exp_w = (k % 2 == 0);
            #1;
            chk($sformatf("alt%0d_gnt", k), {bus.wr_req_ready, bus.rd_req_ready}, {exp_w, ~exp_w});
            step;
            serve(exp_w, 36, $sformatf("alt%0d", k));
        end
        bus.wr_req_valid = 0; bus.rd_req_valid = 0;

        run_job('{1'b1, 12'd1, 12'd2, 1'b0, 72}, "post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_bram_adapter_v1_0_sched.md
Name: axis_bram_adapter_v1_0_sched

Overview:
Job scheduler in front of the AXIS/BRAM adapter controller. Accepts write jobs (AXIS→BRAM) and read jobs (BRAM→AXIS) on two request channels and arbitrates them round-robin. For each granted job it resets and reloads the adapter, drives rw/start/bound, and gates the stream handshakes. It detects job completion by counting beats on writes and by tlast on reads, then reports completion.

Parameters:
BRAM_DEPTH, 12, width of BRAM row index
BRAM_WIDTH_IN_WORD, 36, AXIS words per BRAM row
CNT_W, 6, width of the per-row word counter; must satisfy 2^CNT_W >= BRAM_WIDTH_IN_WORD

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_req_valid  in  1  write job request
wr_req_ready  out  1  write job accepted this cycle
wr_req_start  in  BRAM_DEPTH  first row
wr_req_bound  in  BRAM_DEPTH  last row, inclusive
rd_req_valid  in  1  read job request
rd_req_ready  out  1  read job accepted this cycle
rd_req_start  in  BRAM_DEPTH  first row
rd_req_bound  in  BRAM_DEPTH  last row, inclusive
s_axis_tvalid  in  1  upstream write data valid
s_axis_tready  out  1  upstream ready (gated)
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  downstream valid (gated)
adp_rstn  out  1  active-low reset to adapter controller
adp_rw  out  1  1=write job, 0=read job
adp_addr_reload  out  1  one-cycle index reload pulse
adp_start_index  out  BRAM_DEPTH  registered job start
adp_bound_index  out  BRAM_DEPTH  registered job bound
adp_stream_in_valid  out  1  s_axis_tvalid gated by WR_RUN
adp_stream_in_accep  in  1  adapter input accept
adp_stream_out_accep  out  1  m_axis_tready gated by RD_RUN
adp_stream_out_valid  in  1  adapter output valid
adp_stream_out_tlast  in  1  adapter last-word flag
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_rw  out  1  type of completed or rejected job, held until next done/err
err  out  1  one-cycle pulse: job rejected (bound < start)

Behaviour:
- Reset values: state IDLE, last_grant=read (write wins the first tie), adp_rstn=0 while rst is high and 1 after rst deasserts. adp_rw=1, all indices 0. All ready/valid/pulse outputs 0; done_rw=0.
- States: IDLE, ADP_RST, LOAD, WR_RUN, RD_RUN, DONE.
- IDLE: if exactly one *_req_valid is high, grant it; if both are high, grant the channel not in last_grant. The grant raises that *_req_ready for one cycle. Start and bound are registered, and adp_rw is set from the channel. If bound < start: pulse err the next cycle, set done_rw, stay IDLE, and make no adapter activity. Otherwise go to ADP_RST.
- ADP_RST: adp_rstn=0 for exactly 2 cycles. This clears the adapter's latched out_tlast and its counters. Then go to LOAD.
- LOAD: adp_addr_reload=1 for 1 cycle. Clear row_cnt and word_cnt. Go to WR_RUN if adp_rw=1, else RD_RUN.
- WR_RUN:
  - s_axis_tready = adp_stream_in_accep; adp_stream_in_valid = s_axis_tvalid.
  - A beat is s_axis_tvalid & adp_stream_in_accep. Each beat increments word_cnt, which wraps at BRAM_WIDTH_IN_WORD-1 to 0 and increments row_cnt.
  - row_cnt is BRAM_DEPTH+1 bits, so the range 0..4095 does not overflow.
  - When the beat lands on word BRAM_WIDTH_IN_WORD-1 and row_cnt == bound-start, go to DONE. Total beats = (bound-start+1)*BRAM_WIDTH_IN_WORD.
- RD_RUN:
  - m_axis_tvalid = adp_stream_out_valid; adp_stream_out_accep = m_axis_tready.
  - On a cycle with adp_stream_out_tlast & adp_stream_out_valid & m_axis_tready, go to DONE.
- Outside WR_RUN/RD_RUN, the gated stream outputs are 0, so no handshake leaks to or from the adapter.
- DONE: done=1 for 1 cycle, done_rw=adp_rw, last_grant=adp_rw. Return to IDLE; a new grant is possible on the cycle after DONE.
- Requests are never accepted outside IDLE; *_req_valid may stay high and is held off.
- rst mid-job: everything returns to reset values on the next edge, no done pulse is issued, and the adapter is reset via adp_rstn.
- Latency: from grant to first enabled stream cycle is 4 cycles (grant, ADP_RST×2, LOAD).

Decomposition:
- Shared package: state encoding localparams (ST_IDLE..ST_DONE), ADP_RST_CYCLES=2, grant encoding (GNT_WR=1, GNT_RD=0).
- One natural sub-module: axis_bram_adapter_v1_0_rr_arb, a 2-requester round-robin arbiter with a last_grant register and an enable input; the rest is flat.

Test Plan:
- Write job start=0 bound=1, s_axis_tvalid held high, accep high → exactly 72 beats accepted, then done=1 for one cycle with done_rw=1, and s_axis_tready=0 afterwards.
- Read job start=0 bound=0, m_axis_tready high, adapter model emits tlast on word 36 → done pulse on the tlast handshake cycle, done_rw=0.
- wr_req_valid and rd_req_valid both high and held → grants alternate W,R,W,R across four jobs.
- Write job start=5 bound=3 → err pulse, done_rw=1, adp_rstn stays 1, no addr_reload, state IDLE.
- m_axis_tready low while tlast is presented → stays in RD_RUN with no done; tready high → done next edge.
- rst asserted at beat 10 of a write → next cycle busy=0, all gated outputs 0, no done; a new job then completes normally with 36*(rows) beats.
